hazard_tracker: RTL and testbench

- Decode-stage hazard unit. It consumes the per-instruction timing (Tuse/Tnew) and register addresses produced by the decode-stage control unit.
- It keeps its own E/M/W shadow pipeline of destination/Tnew records.
- It produces stall/enable controls for PC, F/D and D/E registers, plus forwarding-mux selects for the D, E and M stages of the 5-stage MIPS pipeline.

---
 rtl/hazard_tracker_pkg.sv | 26 ++
 rtl/hazard_tracker_fwd_sel.sv | 39 +++
 rtl/hazard_tracker.sv | 162 ++++++++++++++++
 tb/tb_hazard_tracker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hazard_tracker_pkg.sv
// Shared constants for the decode-stage hazard tracker: Tuse/Tnew timing codes
// and the forwarding-mux select encodings used by the D, E and M stages.
package hazard_tracker_pkg;

    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_PC8  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    localparam logic [1:0] FWD_D_RF  = 2'd0;
    localparam logic [1:0] FWD_D_E   = 2'd1;
    localparam logic [1:0] FWD_D_M   = 2'd2;
    localparam logic [1:0] FWD_D_W   = 2'd3;

    localparam logic [1:0] FWD_E_PIPE = 2'd0;
    localparam logic [1:0] FWD_E_M    = 2'd1;
    localparam logic [1:0] FWD_E_W    = 2'd2;

    localparam logic [1:0] FWD_M_PIPE = 2'd0;
    localparam logic [1:0] FWD_M_W    = 2'd1;

endpackage

// File: rtl/hazard_tracker_fwd_sel.sv
// Priority forwarding selector: the nearest ready stage whose destination
// matches the (non-zero) source address wins; otherwise select 0.
module hazard_fwd_sel
    import hazard_tracker_pkg::*;
#(
    parameter int         AW   = 5,
    parameter logic [1:0] SEL1 = 2'd1,
    parameter logic [1:0] SEL2 = 2'd2,
    parameter logic [1:0] SEL3 = 2'd3
) (
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] s1_addr,
    input  logic          s1_rdy,
    input  logic [AW-1:0] s2_addr,
    input  logic          s2_rdy,
    input  logic [AW-1:0] s3_addr,
    input  logic          s3_rdy,
    output logic [1:0]    sel
);

    // Priority match, nearest stage first; register 0 never forwards.
    always_comb begin
        sel = 2'd0;
        if (addr != '0) begin
            if (s1_rdy && (addr == s1_addr)) begin
                sel = SEL1;
            end else if (s2_rdy && (addr == s2_addr)) begin
                sel = SEL2;
            end else if (s3_rdy && (addr == s3_addr)) begin
                sel = SEL3;
            end else begin
                sel = 2'd0;
            end
        end else begin
            sel = 2'd0;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Decode-stage hazard unit with its own E/M/W shadow records of destination and Tnew.
// Optional HAZARD_STATS_EN adds a 32-bit StallCount output.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int TW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] A1D,
    input  logic [REG_AW-1:0] A2D,
    input  logic [REG_AW-1:0] A3D,
    input  logic [TW-1:0]     TuseRsD,
    input  logic [TW-1:0]     TuseRtD,
    input  logic [TW-1:0]     TnewD,
    output logic              Stall,
    output logic              PCEn,
    output logic              FDEn,
    output logic              DEClr,
    output logic [1:0]        FwdRsD,
    output logic [1:0]        FwdRtD,
    output logic [1:0]        FwdRsE,
    output logic [1:0]        FwdRtE,
    output logic              FwdRtM
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       StallCount
`endif
);

    logic [REG_AW-1:0] a1_e_q, a1_e_d;
    logic [REG_AW-1:0] a2_e_q, a2_e_d;
    logic [REG_AW-1:0] a3_e_q, a3_e_d;
    logic [TW-1:0]     tnew_e_q, tnew_e_d;
    logic [REG_AW-1:0] a2_m_q, a2_m_d;
    logic [REG_AW-1:0] a3_m_q, a3_m_d;
    logic [TW-1:0]     tnew_m_q, tnew_m_d;
    logic [REG_AW-1:0] a3_w_q, a3_w_d;

    logic stall_rs_s;
    logic stall_rt_s;
    logic stall_s;
    logic rdy_e_s;
    logic rdy_m_s;
    logic [REG_AW-1:0] zero_addr_s;
    logic [1:0] fwd_rt_m_sel_s;

    // Stall detection: an operand needed before its producer's result is ready.
    always_comb begin
        stall_rs_s = (A1D != '0) &&
                     (((A1D == a3_e_q) && (TuseRsD < tnew_e_q)) ||
                      ((A1D == a3_m_q) && (TuseRsD < tnew_m_q)));
        stall_rt_s = (A2D != '0) &&
                     (((A2D == a3_e_q) && (TuseRtD < tnew_e_q)) ||
                      ((A2D == a3_m_q) && (TuseRtD < tnew_m_q)));
        stall_s    = stall_rs_s || stall_rt_s;
        rdy_e_s    = (tnew_e_q == '0);
        rdy_m_s    = (tnew_m_q == '0);
        zero_addr_s = '0;
    end

    // Shadow-pipeline advance: bubble into E on stall, M/W always advance.
    always_comb begin
        if (stall_s) begin
            a1_e_d   = '0;
            a2_e_d   = '0;
            a3_e_d   = '0;
            tnew_e_d = '0;
        end else begin
            a1_e_d   = A1D;
            a2_e_d   = A2D;
            a3_e_d   = A3D;
            tnew_e_d = TnewD;
        end
        a2_m_d   = a2_e_q;
        a3_m_d   = a3_e_q;
        tnew_m_d = (tnew_e_q == '0) ? '0 : (tnew_e_q - TW'(1));
        a3_w_d   = a3_m_q;
    end

    // Record registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a1_e_q   <= '0;
            a2_e_q   <= '0;
            a3_e_q   <= '0;
            tnew_e_q <= '0;
            a2_m_q   <= '0;
            a3_m_q   <= '0;
            tnew_m_q <= '0;
            a3_w_q   <= '0;
        end else begin
            a1_e_q   <= a1_e_d;
            a2_e_q   <= a2_e_d;
            a3_e_q   <= a3_e_d;
            tnew_e_q <= tnew_e_d;
            a2_m_q   <= a2_m_d;
            a3_m_q   <= a3_m_d;
            tnew_m_q <= tnew_m_d;
            a3_w_q   <= a3_w_d;
        end
    end

    assign Stall = stall_s;
    assign PCEn  = ~stall_s;
    assign FDEn  = ~stall_s;
    assign DEClr = stall_s;

    hazard_fwd_sel #(.AW(REG_AW), .SEL1(FWD_D_E), .SEL2(FWD_D_M), .SEL3(FWD_D_W)) u_fwd_rs_d (
        .addr(A1D), .s1_addr(a3_e_q), .s1_rdy(rdy_e_s), .s2_addr(a3_m_q), .s2_rdy(rdy_m_s),
        .s3_addr(a3_w_q), .s3_rdy(1'b1), .sel(FwdRsD)
    );

    hazard_fwd_sel #(.AW(REG_AW), .SEL1(FWD_D_E), .SEL2(FWD_D_M), .SEL3(FWD_D_W)) u_fwd_rt_d (
        .addr(A2D), .s1_addr(a3_e_q), .s1_rdy(rdy_e_s), .s2_addr(a3_m_q), .s2_rdy(rdy_m_s),
        .s3_addr(a3_w_q), .s3_rdy(1'b1), .sel(FwdRtD)
    );

    // E and M selectors have fewer sources; the unused slots are tied off.
    hazard_fwd_sel #(.AW(REG_AW), .SEL1(FWD_E_M), .SEL2(FWD_E_W), .SEL3(FWD_E_PIPE)) u_fwd_rs_e (
        .addr(a1_e_q), .s1_addr(a3_m_q), .s1_rdy(rdy_m_s), .s2_addr(a3_w_q), .s2_rdy(1'b1),
        .s3_addr(zero_addr_s), .s3_rdy(1'b0), .sel(FwdRsE)
    );

    hazard_fwd_sel #(.AW(REG_AW), .SEL1(FWD_E_M), .SEL2(FWD_E_W), .SEL3(FWD_E_PIPE)) u_fwd_rt_e (
        .addr(a2_e_q), .s1_addr(a3_m_q), .s1_rdy(rdy_m_s), .s2_addr(a3_w_q), .s2_rdy(1'b1),
        .s3_addr(zero_addr_s), .s3_rdy(1'b0), .sel(FwdRtE)
    );

    hazard_fwd_sel #(.AW(REG_AW), .SEL1(FWD_M_W), .SEL2(FWD_M_PIPE), .SEL3(FWD_M_PIPE)) u_fwd_rt_m (
        .addr(a2_m_q), .s1_addr(a3_w_q), .s1_rdy(1'b1), .s2_addr(zero_addr_s), .s2_rdy(1'b0),
        .s3_addr(zero_addr_s), .s3_rdy(1'b0), .sel(fwd_rt_m_sel_s)
    );

    assign FwdRtM = (fwd_rt_m_sel_s == FWD_M_W);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Stall cycle counter; wraps naturally at 2^32.
    always_comb begin
        if (stall_s) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed self-checking bench for hazard_tracker; checks StallCount when
// HAZARD_STATS_EN is defined.
module tb_hazard_tracker;

    logic       clk;
    logic       reset;
    logic [4:0] A1D, A2D, A3D;
    logic [1:0] TuseRsD, TuseRtD, TnewD;
    logic       Stall, PCEn, FDEn, DEClr;
    logic [1:0] FwdRsD, FwdRtD, FwdRsE, FwdRtE;
    logic       FwdRtM;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCount;
`endif

    int checks_cnt;
    int errors_cnt;

    hazard_tracker #(.REG_AW(5), .TW(2)) dut (
        .clk(clk), .reset(reset),
        .A1D(A1D), .A2D(A2D), .A3D(A3D),
        .TuseRsD(TuseRsD), .TuseRtD(TuseRtD), .TnewD(TnewD),
        .Stall(Stall), .PCEn(PCEn), .FDEn(FDEn), .DEClr(DEClr),
        .FwdRsD(FwdRsD), .FwdRtD(FwdRtD), .FwdRsE(FwdRsE), .FwdRtE(FwdRtE),
        .FwdRtM(FwdRtM)
`ifdef HAZARD_STATS_EN
        , .StallCount(StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then present the next D-stage instruction.
    task automatic step_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                          input logic [1:0] trs, input logic [1:0] trt, input logic [1:0] tn);
        @(posedge clk);
        #1;
        A1D = a1; A2D = a2; A3D = a3;
        TuseRsD = trs; TuseRtD = trt; TnewD = tn;
        #1;
    endtask

    task automatic nop();
        step_d(5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0);
    endtask

    task automatic flush();
        nop(); nop(); nop();
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        reset = 1'b0;
        A1D = 5'd0; A2D = 5'd0; A3D = 5'd0;
        TuseRsD = 2'd3; TuseRtD = 2'd3; TnewD = 2'd0;

        nop(); nop();
        check_val("rst_stall", {31'd0, Stall}, 32'd0);
        check_val("rst_pcen", {31'd0, PCEn}, 32'd1);
        check_val("rst_fden", {31'd0, FDEn}, 32'd1);
        check_val("rst_declr", {31'd0, DEClr}, 32'd0);
        check_val("rst_fwd", {24'd0, FwdRsD, FwdRtD, FwdRsE, FwdRtE}, 32'd0);
        check_val("rst_fwdm", {31'd0, FwdRtM}, 32'd0);
`ifdef HAZARD_STATS_EN
        check_val("rst_cnt", StallCount, 32'd0);
`endif
        reset = 1'b1;
        flush();

        // Load-use: lw $8 then add using $8 in E.
        step_d(5'd29, 5'd0, 5'd8, 2'd1, 2'd3, 2'd2);
        check_val("lu_nostall0", {31'd0, Stall}, 32'd0);
        step_d(5'd8, 5'd0, 5'd10, 2'd1, 2'd3, 2'd1);
        check_val("lu_stall", {31'd0, Stall}, 32'd1);
        check_val("lu_declr", {31'd0, DEClr}, 32'd1);
        check_val("lu_pcen", {31'd0, PCEn}, 32'd0);
        check_val("lu_fden", {31'd0, FDEn}, 32'd0);
        step_d(5'd8, 5'd0, 5'd10, 2'd1, 2'd3, 2'd1);
        check_val("lu_release", {31'd0, Stall}, 32'd0);
        check_val("lu_fwdrsd", {30'd0, FwdRsD}, 32'd0);
        nop();
        check_val("lu_fwdrse_w", {30'd0, FwdRsE}, 32'd2);
        flush();

        // Branch after ALU result.
        step_d(5'd2, 5'd3, 5'd9, 2'd1, 2'd1, 2'd1);
        step_d(5'd9, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0);
        check_val("br_stall", {31'd0, Stall}, 32'd1);
        step_d(5'd9, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0);
        check_val("br_release", {31'd0, Stall}, 32'd0);
        check_val("br_fwdrsd_m", {30'd0, FwdRsD}, 32'd2);
        flush();

        // jal then immediate use of $31.
        step_d(5'd0, 5'd0, 5'd31, 2'd3, 2'd3, 2'd0);
        step_d(5'd31, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0);
        check_val("jal_stall", {31'd0, Stall}, 32'd0);
        check_val("jal_fwdrsd_e", {30'd0, FwdRsD}, 32'd1);
        flush();

        // Back-to-back ALU.
        step_d(5'd1, 5'd2, 5'd4, 2'd1, 2'd1, 2'd1);
        step_d(5'd4, 5'd0, 5'd6, 2'd1, 2'd3, 2'd1);
        check_val("b2b_stall", {31'd0, Stall}, 32'd0);
        check_val("b2b_fwdrsd", {30'd0, FwdRsD}, 32'd0);
        step_d(5'd4, 5'd0, 5'd7, 2'd1, 2'd3, 2'd1);
        check_val("b2b_stall2", {31'd0, Stall}, 32'd0);
        check_val("b2b_fwdrse_m", {30'd0, FwdRsE}, 32'd1);
        nop();
        check_val("b2b_fwdrse_w", {30'd0, FwdRsE}, 32'd2);
        flush();

        // Register 0 never stalls or forwards.
        step_d(5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd2);
        step_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
        check_val("r0_stall", {31'd0, Stall}, 32'd0);
        step_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
        check_val("r0_stall2", {31'd0, Stall}, 32'd0);
        check_val("r0_fwdd", {28'd0, FwdRsD, FwdRtD}, 32'd0);
        nop();
        check_val("r0_fwde", {28'd0, FwdRsE, FwdRtE}, 32'd0);
        check_val("r0_fwdm", {31'd0, FwdRtM}, 32'd0);
        flush();

        // Load then store of the loaded register.
        step_d(5'd29, 5'd0, 5'd5, 2'd1, 2'd3, 2'd2);
        step_d(5'd29, 5'd5, 5'd0, 2'd1, 2'd2, 2'd0);
        check_val("st_stall", {31'd0, Stall}, 32'd0);
        nop();
        check_val("st_fwdrte", {30'd0, FwdRtE}, 32'd0);
        nop();
        check_val("st_fwdrtm", {31'd0, FwdRtM}, 32'd1);
        flush();

        // Two loads to $8 in E and M: stall spans both, then forward from W.
        step_d(5'd29, 5'd0, 5'd8, 2'd1, 2'd3, 2'd2);
        step_d(5'd29, 5'd0, 5'd8, 2'd1, 2'd3, 2'd2);
        step_d(5'd8, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0);
        check_val("dual_stall1", {31'd0, Stall}, 32'd1);
        step_d(5'd8, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0);
        check_val("dual_stall2", {31'd0, Stall}, 32'd1);
        step_d(5'd8, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0);
        check_val("dual_release", {31'd0, Stall}, 32'd0);
        check_val("dual_fwdrsd_w", {30'd0, FwdRsD}, 32'd3);
        flush();

        // Reset asserted while stalled.
        step_d(5'd29, 5'd0, 5'd8, 2'd1, 2'd3, 2'd2);
        step_d(5'd8, 5'd0, 5'd10, 2'd1, 2'd3, 2'd1);
        check_val("rms_stall", {31'd0, Stall}, 32'd1);
`ifdef HAZARD_STATS_EN
        check_val("rms_cnt_pre", StallCount, 32'd4);
`endif
        reset = 1'b0;
        step_d(5'd8, 5'd0, 5'd10, 2'd1, 2'd3, 2'd1);
        check_val("rms_stall_clr", {31'd0, Stall}, 32'd0);
        check_val("rms_pcen", {31'd0, PCEn}, 32'd1);
        check_val("rms_fwd", {24'd0, FwdRsD, FwdRtD, FwdRsE, FwdRtE}, 32'd0);
        check_val("rms_fwdm", {31'd0, FwdRtM}, 32'd0);
`ifdef HAZARD_STATS_EN
        check_val("rms_cnt", StallCount, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
